// File: rtl/uart_pkg.sv
// UART shared definitions: FSM states, default bit period
// and frame levels, reused by transmitter and receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  localparam int CLKS_PER_BIT_DEF = 18;
  localparam int DATA_BITS = 8;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL = 1'b1;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled,
// ticks on the last count and restarts at each bit boundary.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clock,
  input  logic clear,
  input  logic enable,
  input  logic restart,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

  logic [15:0] count;

  assign tick = (count == LAST);

  always_ff @(posedge clock) begin
    if (clear || restart || !enable || tick) begin
      count <= '0;
    end else begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one-byte holding register feeding an
// 8N1 serializer with a registered line output.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clock,
  input  logic       clear,
  input  logic [7:0] data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       transmit,
  output logic       busy,
  output logic       tx_done
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  uart_state_t state_q;
  uart_state_t state_d;
  logic [2:0]  bit_q;
  logic [2:0]  bit_d;
  logic [2:0]  bit_nx;
  logic [7:0]  shreg;
  logic [7:0]  hold;
  logic        hold_full;
  logic        accept;
  logic        load;
  logic        tick;
  logic        line_d;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clock  (clock),
    .clear  (clear),
    .enable (state_q != IDLE),
    .restart(load),
    .tick   (tick)
  );

  assign tx_ready = !hold_full;
  assign accept   = tx_valid && !hold_full;
  assign busy     = (state_q != IDLE);
  assign tx_done  = (state_q == STOP) && tick;
  assign bit_nx   = bit_q + 3'd1;

  // line_d is the level for the state being entered, so
  // transmit changes on the same edge as the state.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    load    = 1'b0;
    line_d  = transmit;
    unique case (state_q)
      IDLE: begin
        line_d = STOP_LEVEL;
        if (hold_full) begin
          load    = 1'b1;
          state_d = START;
          line_d  = START_LEVEL;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          bit_d   = '0;
          line_d  = shreg[0];
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_q == LAST_BIT) begin
            state_d = STOP;
            line_d  = STOP_LEVEL;
          end else begin
            bit_d  = bit_nx;
            line_d = shreg[bit_nx];
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (hold_full) begin
            load    = 1'b1;
            state_d = START;
            line_d  = START_LEVEL;
          end else begin
            state_d = IDLE;
            line_d  = STOP_LEVEL;
          end
        end
      end
      default: begin
        state_d = IDLE;
        line_d  = STOP_LEVEL;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q   <= IDLE;
      bit_q     <= '0;
      transmit  <= STOP_LEVEL;
      shreg     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      transmit <= line_d;
      if (load) begin
        shreg     <= hold;
        hold_full <= 1'b0;
      end
      if (accept) begin
        hold      <= data;
        hold_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: cycle-level timeline model, mid-bit
// line decoder, directed and random byte streams.
module tb_uart_tx;

  localparam int CPB   = 18;
  localparam int FRAME = 10 * CPB;

  logic       clock    = 1'b0;
  logic       clear    = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] data     = 8'h00;
  logic       tx_ready;
  logic       transmit;
  logic       busy;
  logic       tx_done;

  uart_tx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clock   (clock),
    .clear   (clear),
    .data    (data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .transmit(transmit),
    .busy    (busy),
    .tx_done (tx_done)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  bit armed  = 1'b0;

  // timeline model: active frame and held frame, each
  // with the edge on which its start bit appears
  bit         a_valid = 1'b0;
  int         a_start = 0;
  logic [7:0] a_byte  = 8'h00;
  bit         h_valid = 1'b0;
  int         h_start = 0;
  logic [7:0] h_byte  = 8'h00;
  bit         acc_pulse = 1'b0;
  int         acc_cyc = 0;
  logic [7:0] sent_q[$];

  bit         rx_active = 1'b0;
  int         rx_off = 0;
  logic [7:0] rx_byte = 8'h00;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc);
  endtask

  function automatic bit model_busy();
    return a_valid && (cyc - a_start) < FRAME;
  endfunction

  // At each negedge: check cycle cyc, decode the line,
  // then predict the upcoming edge from current inputs.
  initial begin
    logic [3:0] ev;
    int off;
    int bn;
    int idx;
    logic lv;
    forever begin
      @(negedge clock);
      if (armed) begin
        ev = {1'b1, 1'b0, 1'b0, !h_valid};
        if (a_valid) begin
          off = cyc - a_start;
          if (off >= 0 && off < FRAME) begin
            bn = off / CPB;
            if (bn == 0) lv = 1'b0;
            else if (bn == 9) lv = 1'b1;
            else lv = a_byte[bn-1];
            ev = {lv, 1'b1, off == FRAME - 1, !h_valid};
          end
        end
        check("line/busy/done/ready",
              {transmit, busy, tx_done, tx_ready}, ev);

        if (!rx_active) begin
          if (transmit === 1'b0) begin
            rx_active = 1'b1;
            rx_off = 0;
          end
        end else begin
          rx_off++;
        end
        if (rx_active && rx_off % CPB == CPB / 2) begin
          idx = rx_off / CPB;
          if (idx == 0) begin
            check("rx_start", transmit, 0);
          end else if (idx <= 8) begin
            rx_byte[idx-1] = transmit;
          end else begin
            check("rx_stop", transmit, 1);
            if (sent_q.size() == 0)
              check("rx_extra", rx_byte, 32'hffff_ffff);
            else
              check("rx_byte", rx_byte, sent_q.pop_front());
            rx_active = 1'b0;
          end
        end
      end

      cyc++;
      if (clear) begin
        armed = 1'b1;
        a_valid = 1'b0;
        h_valid = 1'b0;
        acc_pulse = 1'b0;
        rx_active = 1'b0;
        sent_q.delete();
      end else begin
        acc_pulse = tx_valid && !h_valid;
        if (h_valid && h_start == cyc) begin
          a_valid = 1'b1;
          a_start = h_start;
          a_byte  = h_byte;
          h_valid = 1'b0;
        end
        if (acc_pulse) begin
          h_valid = 1'b1;
          h_byte  = data;
          acc_cyc = cyc;
          if (a_valid && a_start + FRAME > cyc + 1)
            h_start = a_start + FRAME;
          else
            h_start = cyc + 1;
          sent_q.push_back(data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_edge(input int target);
    while (cyc < target) step();
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((h_valid || model_busy()) && n < 3000) begin
      step();
      n++;
    end
    if (n >= 3000) check("idle_timeout", 0, 1);
  endtask

  task automatic send_byte(input logic [7:0] b,
                           output int e);
    int n = 0;
    tx_valid = 1'b1;
    data = b;
    e = 0;
    forever begin
      step();
      n++;
      if (acc_pulse) begin
        e = acc_cyc;
        break;
      end
      if (n > 800) begin
        check("accept_timeout", 0, 1);
        e = cyc;
        break;
      end
    end
    tx_valid = 1'b0;
    data = 8'($urandom);
  endtask

  initial begin
    int e, e2, e3, c0, nb, nd, d1, d2, gap;
    logic [7:0] a5;
    logic [7:0] lb [4];

    repeat (3) @(posedge clock);
    #1;
    clear = 1'b0;
    check("rst_line", transmit, 1);
    check("rst_busy", busy, 0);
    check("rst_ready", tx_ready, 1);
    check("rst_done", tx_done, 0);
    repeat (4) step();

    send_byte(8'h55, e);
    check("pre_start", transmit, 1);
    wait_edge(e + 1);
    check("start_lat", transmit, 0);
    check("busy_on", busy, 1);
    wait_edge(e + FRAME - 1);
    check("done_early", tx_done, 0);
    wait_edge(e + FRAME);
    check("done_pulse", tx_done, 1);
    wait_edge(e + FRAME + 1);
    check("busy_off", busy, 0);
    check("done_width", tx_done, 0);

    a5 = 8'hA5;
    send_byte(a5, e);
    for (int i = 0; i < 8; i++) begin
      wait_edge(e + 1 + CPB * (i + 1) + CPB / 2);
      check("a5_bit", transmit, a5[i]);
    end
    wait_idle();

    send_byte(8'h00, e);
    send_byte(8'hFF, e2);
    c0 = cyc;
    nb = 0;
    nd = 0;
    d1 = 0;
    d2 = 0;
    while (cyc <= e + 2 * FRAME + 10) begin
      if (busy) nb++;
      if (tx_done) begin
        nd++;
        if (nd == 1) d1 = cyc;
        else d2 = cyc;
      end
      step();
    end
    check("busy_run", nb, e + 2 * FRAME + 1 - c0);
    check("done_cnt", nd, 2);
    check("done1", d1, e + FRAME);
    check("done2", d2, e + 2 * FRAME);

    wait_idle();
    send_byte(8'h81, e);
    send_byte(8'h42, e2);
    check("held_ready", tx_ready, 0);
    send_byte(8'h24, e3);
    check("third_acc", e3, e + FRAME + 2);
    wait_idle();

    send_byte(8'hC3, e);
    send_byte(8'h99, e2);
    wait_edge(e + 1 + CPB * 4 + 5);
    clear = 1'b1;
    tx_valid = 1'b1;
    data = 8'h3C;
    step();
    clear = 1'b0;
    tx_valid = 1'b0;
    check("abort_line", transmit, 1);
    check("abort_busy", busy, 0);
    check("abort_ready", tx_ready, 1);
    nd = 0;
    repeat (2 * FRAME) begin
      if (tx_done) nd++;
      step();
    end
    check("abort_nodone", nd, 0);
    send_byte(8'h5A, e);
    wait_idle();

    lb[0] = 8'h55;
    lb[1] = 8'h00;
    lb[2] = 8'hFF;
    lb[3] = 8'h66;
    for (int i = 0; i < 4; i++) send_byte(lb[i], e);
    wait_idle();

    for (int i = 0; i < 24; i++) begin
      send_byte(8'($urandom), e);
      if ($urandom_range(0, 3) == 0) gap = 0;
      else gap = $urandom_range(1, 250);
      repeat (gap) step();
      if (i == 12) begin
        repeat ($urandom_range(5, 150)) step();
        clear = 1'b1;
        step();
        clear = 1'b0;
      end
    end
    wait_idle();
    repeat (5) step();
    check("rx_drain", sent_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
